// File: rtl/pipeline_batch_scheduler.sv
// Round-robin dispatch of whole bot batches across NUM_PIPES pipelines, with results re-emitted in dispatch order.
// Optional counters and occupancy outputs are enabled with `define SCHEDULER_STATS_EN.
`ifndef PCOEFF_COUNT_BITWIDTH
`define PCOEFF_COUNT_BITWIDTH 16
`endif

module pipeline_batch_scheduler #(
  parameter int NUM_PIPES  = 4,
  parameter int ORDER_LOG2 = 6,
  parameter int COUNT_W    = `PCOEFF_COUNT_BITWIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [127:0]                      bot,
  input  logic                              writeData,
  input  logic [5:0]                        validBotPermutes,
  input  logic                              batchDone,
  output logic                              slowDownInput,
  output logic [127:0]                      pipeBot,
  output logic [5:0]                        pipeValidPermutes,
  output logic                              pipeBatchDone,
  output logic [NUM_PIPES-1:0]              pipeWriteData,
  input  logic [NUM_PIPES-1:0]              pipeSlowDown,
  input  logic [NUM_PIPES-1:0]              pipeResultsAvailable,
  output logic [NUM_PIPES-1:0]              pipeGrabResults,
  input  logic [NUM_PIPES*(COUNT_W+35)-1:0] pipePcoeffSum,
  input  logic [NUM_PIPES*COUNT_W-1:0]      pipePcoeffCount,
  output logic                              resultValid,
  input  logic                              resultReady,
  output logic [COUNT_W+34:0]               resultSum,
  output logic [COUNT_W-1:0]                resultCount,
`ifdef SCHEDULER_STATS_EN
  output logic [31:0]                       batchesDispatched,
  output logic [31:0]                       resultsReturned,
  output logic [ORDER_LOG2:0]               inFlight,
`endif
  output logic                              orderOverflow
);

  localparam int SUM_W  = COUNT_W + 35;
  localparam int PIPE_W = $clog2(NUM_PIPES);
  localparam int DEPTH  = 1 << ORDER_LOG2;
  localparam logic [ORDER_LOG2:0] FULL_LVL = (ORDER_LOG2+1)'(DEPTH);
  localparam logic [ORDER_LOG2:0] SLOW_LVL = (ORDER_LOG2+1)'(DEPTH - 2);

  typedef logic [PIPE_W-1:0] pipe_t;
  typedef enum logic {IDLE, IN_BATCH} state_t;

  state_t                state, stateNext;
  pipe_t                 rrPtr, lockTgt, target, head;
  pipe_t                 orderMem [DEPTH];
  logic [ORDER_LOG2-1:0] wrPtr, rdPtr;
  logic [ORDER_LOG2:0]   used;
  logic                  orderEmpty, orderFull;
  logic                  push, pushOk, grab, slowNext;
  logic [SUM_W-1:0]      sumArr [NUM_PIPES];
  logic [COUNT_W-1:0]    cntArr [NUM_PIPES];

  // First pipeline at or after start (cyclically) that is not slowed; start itself when all are slowed.
  function automatic pipe_t pickTarget(input pipe_t start, input logic [NUM_PIPES-1:0] slow);
    pipe_t pick;
    int    idx;
    pick = start;
    for (int k = NUM_PIPES - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_PIPES) idx = idx - NUM_PIPES;
      if (!slow[pipe_t'(idx)]) pick = pipe_t'(idx);
    end
    return pick;
  endfunction

  function automatic pipe_t nextPtr(input pipe_t p);
    return (int'(p) == NUM_PIPES - 1) ? pipe_t'(0) : pipe_t'(int'(p) + 1);
  endfunction

  function automatic logic [NUM_PIPES-1:0] oneHot(input pipe_t p);
    logic [NUM_PIPES-1:0] oh;
    oh    = '0;
    oh[p] = 1'b1;
    return oh;
  endfunction

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_unpack
    assign sumArr[g] = pipePcoeffSum[g*SUM_W +: SUM_W];
    assign cntArr[g] = pipePcoeffCount[g*COUNT_W +: COUNT_W];
  end

  assign orderEmpty = (used == '0);
  assign orderFull  = (used == FULL_LVL);

  // Dispatch FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    target    = (state == IN_BATCH) ? lockTgt : pickTarget(rrPtr, pipeSlowDown);
    push      = writeData && batchDone;
    if (writeData) stateNext = batchDone ? IDLE : IN_BATCH;
  end

  // Collector: only the oldest dispatched batch may be grabbed
  always_comb begin
    head            = orderMem[rdPtr];
    grab            = !orderEmpty && pipeResultsAvailable[head] && (!resultValid || resultReady);
    pipeGrabResults = grab ? oneHot(head) : '0;
    pushOk          = push && (!orderFull || grab);
    slowNext        = (used >= SLOW_LVL)
                    || ((state == IN_BATCH) && pipeSlowDown[lockTgt])
                    || ((state == IDLE) && (&pipeSlowDown));
  end

  always_ff @(posedge clk) begin
    if (pushOk) orderMem[wrPtr] <= target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr             <= '0;
      lockTgt           <= '0;
      wrPtr             <= '0;
      rdPtr             <= '0;
      used              <= '0;
      orderOverflow     <= 1'b0;
      slowDownInput     <= 1'b0;
      pipeWriteData     <= '0;
      pipeBot           <= '0;
      pipeValidPermutes <= '0;
      pipeBatchDone     <= 1'b0;
      resultValid       <= 1'b0;
      resultSum         <= '0;
      resultCount       <= '0;
    end else begin
      slowDownInput <= slowNext;
      pipeWriteData <= writeData ? oneHot(target) : '0;
      pipeBatchDone <= writeData && batchDone;
      if (writeData) begin
        pipeBot           <= bot;
        pipeValidPermutes <= validBotPermutes;
        lockTgt           <= target;
      end
      if (push) rrPtr <= nextPtr(target);
      if (push && !pushOk) orderOverflow <= 1'b1;
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (grab)   rdPtr <= rdPtr + 1'b1;
      unique case ({pushOk, grab})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: ;
      endcase
      // Result FIFOs are show-ahead: head data is valid in the grab cycle
      if (grab) begin
        resultValid <= 1'b1;
        resultSum   <= sumArr[head];
        resultCount <= cntArr[head];
      end else if (resultReady) begin
        resultValid <= 1'b0;
      end
    end
  end

`ifdef SCHEDULER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      batchesDispatched <= '0;
      resultsReturned   <= '0;
    end else begin
      if (pushOk) batchesDispatched <= batchesDispatched + 32'd1;
      if (grab)   resultsReturned   <= resultsReturned + 32'd1;
    end
  end

  assign inFlight = used;
`endif

endmodule
